// File: rtl/acumulador_4bits.sv
// Accumulator feeding an external combinational 4-bit adder; sticky carry, term count, full flag.
// Define ACUM_SAT_EN to saturate acc at 4'hF on overflow instead of wrapping.
module acumulador_4bits #(
    parameter int MAX_TERMOS = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [3:0] i_in_data,
    output logic [3:0] o_soma_a,
    output logic [3:0] o_soma_b,
    input  logic [3:0] i_soma_res,
    output logic [3:0] o_acc,
    output logic       o_carry,
    output logic [3:0] o_count,
    output logic       o_cheio,
    output logic       o_out_valid
);

    // state  | meaning
    // OCIOSO | idle, may accept an operand
    // SOMA   | operand latched, adder result captured at next edge
    typedef enum logic {OCIOSO, SOMA} state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_TERMOS);

    state_t     r_state;
    logic [3:0] r_acc;
    logic [3:0] r_opnd;
    logic [3:0] r_count;
    logic       r_carry;
    logic       r_out_valid;

    logic       w_overflow;
    logic       w_cheio;
    logic       w_in_ready;
    logic [3:0] w_acc_next;

    // the adder has no carry port: a 4-bit sum smaller than acc means it wrapped
    assign w_overflow = (i_soma_res < r_acc);
    assign w_cheio    = (r_count == LP_MAX);
    assign w_in_ready = (r_state == OCIOSO) && !w_cheio && !i_clear;

    always_comb begin
        w_acc_next = i_soma_res;
`ifdef ACUM_SAT_EN
        if (w_overflow) begin
            w_acc_next = 4'hF;
        end
`else
        w_acc_next = i_soma_res;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= OCIOSO;
            r_acc       <= 4'd0;
            r_opnd      <= 4'd0;
            r_count     <= 4'd0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (i_clear) begin
            r_state     <= OCIOSO;
            r_acc       <= 4'd0;
            r_opnd      <= 4'd0;
            r_count     <= 4'd0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                OCIOSO: begin
                    r_out_valid <= 1'b0;
                    if (i_in_valid && w_in_ready) begin
                        r_opnd  <= i_in_data;
                        r_state <= SOMA;
                    end
                end
                SOMA: begin
                    r_acc       <= w_acc_next;
                    r_carry     <= r_carry | w_overflow;
                    r_count     <= r_count + 4'd1;
                    r_out_valid <= 1'b1;
                    r_state     <= OCIOSO;
                end
                default: begin
                    r_state     <= OCIOSO;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_soma_a    = r_acc;
    assign o_soma_b    = r_opnd;
    assign o_acc       = r_acc;
    assign o_carry     = r_carry;
    assign o_count     = r_count;
    assign o_cheio     = w_cheio;
    assign o_out_valid = r_out_valid;

endmodule

// File: doc/acumulador_4bits.md
# acumulador_4bits

Sequential accumulator that sits directly downstream of the combinational 4-bit adder `somador_4bits`. It accepts 4-bit operands over a valid/ready handshake and drives the adder's `a` input with the running sum and its `b` input with the latched operand. It registers the adder's `res` back as the new sum, and reports a sticky carry-out plus a count of accepted terms. The adder has no carry port, so overflow is detected in this block.

## Interface
- `MAX_TERMOS`, default 15: number of terms accepted before `cheio` asserts. Legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clear`  in  1  synchronous clear; highest priority after `rst`.
- `in_valid`  in  1  operand valid.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  4  operand.
- `soma_a`  out  4  to adder `a`; always equals `acc`.
- `soma_b`  out  4  to adder `b`; equals the latched operand register `opnd`.
- `soma_res`  in  4  from adder `res`.
- `acc`  out  4  running sum.
- `carry`  out  1  sticky overflow flag.
- `count`  out  4  number of terms accepted since the last reset or clear.
- `cheio`  out  1  high when `count == MAX_TERMOS`.
- `out_valid`  out  1  one-cycle pulse after each `acc` update.

## Operation
- Clock is `clk`. Reset `rst` is asynchronous and active-high.
- Two-state FSM:
  - `OCIOSO`: `in_ready = !cheio && !clear`. A handshake (`in_valid && in_ready` at a rising edge) loads `opnd <= in_data` and moves to `SOMA`.
  - `SOMA`: `in_ready = 0`. At the next edge:
    - `acc <= soma_res`, or the saturated value (see Configuration).
    - `carry <= carry | (soma_res < acc)`. This is the 4-bit wrap detect.
    - `count <= count + 1`.
    - `out_valid <= 1`.
    - Return to `OCIOSO`.
- `out_valid` is registered. It is high for exactly one cycle after each `SOMA` edge and is low at all other times.
- Operand value 0 is accepted normally: `acc` is unchanged, `count` increments, `carry` is unaffected.
- `cheio`:
  - Once `count == MAX_TERMOS`, `in_ready` stays low until `clear` or `rst`.
  - `count` never exceeds `MAX_TERMOS`.
- `clear` high at an edge, in any state:
  - `acc`, `opnd`, `count`, `carry`, `out_valid` go to 0; state goes to `OCIOSO`.
  - An in-flight `SOMA` is discarded.
  - `in_valid` in the same cycle is ignored, because `in_ready` is 0 while `clear` is high.
- `rst` asserted: outputs go to their reset values immediately, regardless of state.
- Reset values: `acc = 0`, `opnd = 0`, `soma_a = 0`, `soma_b = 0`, `carry = 0`, `count = 0`, `cheio = 0`, `out_valid = 0`, `in_ready = 1`, state `OCIOSO`.

## Timing
- Handshake accepted at edge N. `acc`, `carry` and `count` update at edge N+1. `out_valid` is high from edge N+1 to edge N+2.
- Throughput: one term every 2 cycles. `in_ready` is low for the cycle spent in `SOMA`.
- The adder path `soma_a`/`soma_b` → `soma_res` is combinational inside a single cycle. `soma_res` is sampled only at the `SOMA` edge.
- `in_ready` depends only on state, `cheio` and `clear`. There is no combinational path from `in_valid`.

## Configuration
- `ACUM_SAT_EN` defined: on overflow (`soma_res < acc`), `acc <= 4'hF`. Once `acc` is 15 it stays 15 for any further operand; `carry` is still set.
- `ACUM_SAT_EN` undefined: `acc` wraps modulo 16 (`acc <= soma_res`). `carry` behaves identically in both builds.

## Test plan
- Reset, then present 1, 2, 5, 3 back-to-back with `in_valid` held high → `acc` steps 1, 3, 8, 0xB; `count = 4`; `carry = 0`; four `out_valid` pulses, each 2 cycles apart.
- From `acc = 0xB`, send 6 → without the macro: `acc = 1`, `carry = 1`. With `ACUM_SAT_EN`: `acc = 0xF`, `carry = 1`. A following 3 leaves `carry = 1`; `acc` becomes 4 without the macro and stays 0xF with it.
- `MAX_TERMOS = 3`: send 1, 1, 1, 1 → `acc = 3`, `cheio = 1`, `in_ready = 0`, fourth operand not accepted. Then pulse `clear` → `acc = 0`, `cheio = 0`, `in_ready = 1`.
- Assert `clear` in the same cycle as `in_valid` with `in_data = 7` → no handshake; `acc = 0`, `count = 0`; no `out_valid` pulse.
- Assert `rst` asynchronously mid-`SOMA` (operand 5 latched, `acc = 3`) → `acc = 0`, `count = 0`, `carry = 0`, `out_valid = 0` immediately, before the next edge. After release, `in_ready = 1`.
- Send operand 0 with `acc = 4` → `acc = 4`, `count` increments, `carry` unchanged, one `out_valid` pulse.
